// File: rtl/cam_array.sv
// cam_array: content-addressable memory with DEPTH entries of DATA_W bits.
// Search results are registered and the lowest matching index wins. Writes
// store a word or invalidate a single entry. A flush request walks every
// entry, clearing one valid bit per cycle.
// Optional build macro CAM_MULTI_HIT_EN adds the cam_multi_hit_out and
// cam_hit_count_out outputs.
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | searches and writes accepted, cam_flush starts a flush
//   ST_FLUSH | one entry invalidated per cycle, all inputs ignored, busy=1
module cam_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_wr_en,
  input  logic [ADDR_W-1:0] cam_wr_addr,
  input  logic [DATA_W-1:0] cam_wr_data,
  input  logic              cam_wr_valid,
  input  logic              cam_flush,
  input  logic              cam_enable,
  input  logic [DATA_W-1:0] cam_data_in,
  output logic              cam_hit_out,
  output logic [ADDR_W-1:0] cam_addr_out,
  output logic              cam_busy
`ifdef CAM_MULTI_HIT_EN
  ,
  output logic              cam_multi_hit_out,
  output logic [ADDR_W:0]   cam_hit_count_out
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [ADDR_W:0]     r_cnt;
  logic                r_busy;
  logic [DEPTH-1:0]    r_valid;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DEPTH-1:0]    w_match;
  logic                w_any;
  logic [ADDR_W-1:0]   w_low;
  logic                w_wr_ok;
  logic                w_search;

  // A write is accepted only in IDLE, in range, and when no flush is requested
  assign w_wr_ok  = (r_state == ST_IDLE) && cam_wr_en && !cam_flush &&
                    ({1'b0, cam_wr_addr} < LP_DEPTH);
  assign w_search = (r_state == ST_IDLE) && cam_enable;
  assign cam_busy = r_busy;

  // Per-entry match against the pre-write contents
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_mem[i] == cam_data_in);
    end
  end

  // Lowest-index priority encode of the match vector
  always_comb begin
    w_any = |w_match;
    w_low = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) w_low = ADDR_W'(i);
    end
  end

  // Data words are not reset; valid bits alone decide whether an entry matches
  always_ff @(posedge clk) begin
    if (w_wr_ok && cam_wr_valid) r_mem[cam_wr_addr] <= cam_wr_data;
  end

  // Flush FSM, flush counter and valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cam_flush) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_wr_ok) begin
            r_valid[cam_wr_addr] <= cam_wr_valid;
          end
        end
        ST_FLUSH: begin
          r_valid[r_cnt[ADDR_W-1:0]] <= 1'b0;
          r_cnt <= r_cnt + LP_ONE;
          if (r_cnt == LP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered search result, zeroed on miss, idle search or busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_hit_out  <= 1'b0;
      cam_addr_out <= '0;
    end else if (w_search && w_any) begin
      cam_hit_out  <= 1'b1;
      cam_addr_out <= w_low;
    end else begin
      cam_hit_out  <= 1'b0;
      cam_addr_out <= '0;
    end
  end

`ifdef CAM_MULTI_HIT_EN
  logic [ADDR_W:0] w_count;

  // Population count of the match vector
  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + (ADDR_W+1)'(w_match[i]);
    end
  end

  // Registered multi-hit flag and hit count, same zeroing as cam_hit_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_multi_hit_out <= 1'b0;
      cam_hit_count_out <= '0;
    end else if (w_search) begin
      cam_multi_hit_out <= (w_count >= (ADDR_W+1)'(2));
      cam_hit_count_out <= w_count;
    end else begin
      cam_multi_hit_out <= 1'b0;
      cam_hit_count_out <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_cam_array.sv
// tb_cam_array: directed self-checking bench for cam_array (defaults).
module tb_cam_array;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              cam_wr_en;
  logic [ADDR_W-1:0] cam_wr_addr;
  logic [DATA_W-1:0] cam_wr_data;
  logic              cam_wr_valid;
  logic              cam_flush;
  logic              cam_enable;
  logic [DATA_W-1:0] cam_data_in;
  logic              cam_hit_out;
  logic [ADDR_W-1:0] cam_addr_out;
  logic              cam_busy;
`ifdef CAM_MULTI_HIT_EN
  logic              cam_multi_hit_out;
  logic [ADDR_W:0]   cam_hit_count_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cam_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cam_wr_en    (cam_wr_en),
    .cam_wr_addr  (cam_wr_addr),
    .cam_wr_data  (cam_wr_data),
    .cam_wr_valid (cam_wr_valid),
    .cam_flush    (cam_flush),
    .cam_enable   (cam_enable),
    .cam_data_in  (cam_data_in),
    .cam_hit_out  (cam_hit_out),
    .cam_addr_out (cam_addr_out),
    .cam_busy     (cam_busy)
`ifdef CAM_MULTI_HIT_EN
    ,
    .cam_multi_hit_out (cam_multi_hit_out),
    .cam_hit_count_out (cam_hit_count_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic v);
    cam_wr_en    = 1'b1;
    cam_wr_addr  = a;
    cam_wr_data  = d;
    cam_wr_valid = v;
    tick();
    cam_wr_en    = 1'b0;
  endtask

  task automatic do_search(input logic [DATA_W-1:0] d);
    cam_enable  = 1'b1;
    cam_data_in = d;
    tick();
    cam_enable  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic hit, input logic [ADDR_W-1:0] a);
    chk({tag, "_hit"}, 32'(cam_hit_out), 32'(hit));
    chk({tag, "_addr"}, 32'(cam_addr_out), 32'(a));
  endtask

  initial begin
    int n_busy;
    rst_n        = 1'b0;
    cam_wr_en    = 1'b0;
    cam_wr_addr  = '0;
    cam_wr_data  = '0;
    cam_wr_valid = 1'b0;
    cam_flush    = 1'b0;
    cam_enable   = 1'b0;
    cam_data_in  = '0;
    #3;
    chk("rst_busy", 32'(cam_busy), 32'd0);
    chk_res("rst", 1'b0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_search(16'h0000);
    chk_res("empty", 1'b0, '0);

    // single entry hit / near miss
    do_write(4'd5, 16'hBEEF, 1'b1);
    do_search(16'hBEEF);
    chk_res("beef", 1'b1, 4'd5);
`ifdef CAM_MULTI_HIT_EN
    chk("beef_cnt", 32'(cam_hit_count_out), 32'd1);
    chk("beef_multi", 32'(cam_multi_hit_out), 32'd0);
`endif
    tick();
    chk_res("enable_low", 1'b0, '0);
    do_search(16'hBEEE);
    chk_res("beee", 1'b0, '0);

    // two matches, lowest index wins
    do_write(4'd9, 16'h1234, 1'b1);
    do_write(4'd3, 16'h1234, 1'b1);
    do_search(16'h1234);
    chk_res("dual", 1'b1, 4'd3);
`ifdef CAM_MULTI_HIT_EN
    chk("dual_multi", 32'(cam_multi_hit_out), 32'd1);
    chk("dual_cnt", 32'(cam_hit_count_out), 32'd2);
`endif

    // search in the same cycle as the write sees old contents
    cam_wr_en = 1'b1; cam_wr_addr = 4'd2; cam_wr_data = 16'hAAAA; cam_wr_valid = 1'b1;
    cam_enable = 1'b1; cam_data_in = 16'hAAAA;
    tick();
    cam_wr_en = 1'b0;
    chk_res("wr_same", 1'b0, '0);
    tick();
    cam_enable = 1'b0;
    chk_res("wr_after", 1'b1, 4'd2);

    // invalidate
    do_write(4'd7, 16'h00FF, 1'b1);
    do_search(16'h00FF);
    chk_res("ff_valid", 1'b1, 4'd7);
    do_write(4'd7, 16'h00FF, 1'b0);
    do_search(16'h00FF);
    chk_res("ff_inval", 1'b0, '0);

    // fill all, flush together with a write (flush wins)
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), 16'h1000 + 16'(i), 1'b1);
    do_search(16'h100F);
    chk_res("fill_last", 1'b1, 4'd15);
    cam_flush = 1'b1;
    cam_wr_en = 1'b1; cam_wr_addr = 4'd0; cam_wr_data = 16'h5555; cam_wr_valid = 1'b1;
    tick();
    cam_flush = 1'b0;
    chk("flush_start", 32'(cam_busy), 32'd1);
    n_busy = 1;
    cam_wr_addr = 4'd4; cam_wr_data = 16'h7777;
    cam_enable  = 1'b1; cam_data_in = 16'h100F;
    cam_flush   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("flush_nohit", 32'(cam_hit_out), 32'd0);
      if (!cam_busy) break;
      n_busy++;
    end
    cam_wr_en = 1'b0; cam_enable = 1'b0; cam_flush = 1'b0;
    chk("flush_len", 32'(n_busy), 32'd16);
    do_search(16'h100F);
    chk_res("post_f15", 1'b0, '0);
    do_search(16'h1003);
    chk_res("post_f3", 1'b0, '0);
    do_search(16'h7777);
    chk_res("post_wr", 1'b0, '0);
    do_search(16'h5555);
    chk_res("post_drop", 1'b0, '0);
    do_write(4'd3, 16'hABCD, 1'b1);
    do_search(16'hABCD);
    chk_res("post_new", 1'b1, 4'd3);

    // reset during cycle 6 of a flush
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), 16'h2000 + 16'(i), 1'b1);
    cam_flush = 1'b1;
    tick();
    cam_flush = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_busy", 32'(cam_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(cam_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle_busy", 32'(cam_busy), 32'd0);
    do_search(16'h200A);
    chk_res("rst_f10", 1'b0, '0);
    do_search(16'h200F);
    chk_res("rst_f15", 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_array.md
CAM_ARRAY -- requirements
Module: cam_array

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the stored and search word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of CAM entries (legal range 2..256).
REQ-003 The block SHALL have parameter ADDR_W, default 4, giving the entry address width; DEPTH <= 2**ADDR_W is required.
Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cam_wr_en, input, 1 bit: write strobe for one entry.
REQ-007 The block SHALL have port cam_wr_addr, input, ADDR_W bits: entry index to write.
REQ-008 The block SHALL have port cam_wr_data, input, DATA_W bits: word to store.
REQ-009 The block SHALL have port cam_wr_valid, input, 1 bit: 1 = store and mark the entry valid; 0 = invalidate the entry.
REQ-010 The block SHALL have port cam_flush, input, 1 bit: single-cycle request to invalidate all entries.
REQ-011 The block SHALL have port cam_enable, input, 1 bit: search request.
REQ-012 The block SHALL have port cam_data_in, input, DATA_W bits: search key.
REQ-013 The block SHALL have port cam_hit_out, output, 1 bit: registered match flag.
REQ-014 The block SHALL have port cam_addr_out, output, ADDR_W bits: registered lowest matching index.
REQ-015 The block SHALL have port cam_busy, output, 1 bit: flush in progress.

Function
REQ-016 An entry SHALL match when its valid bit is 1 and its stored word equals cam_data_in on all DATA_W bits.
REQ-017 A search SHALL have 1-cycle latency: with cam_enable=1 at edge N, outputs SHALL reflect the result from edge N onward; the lowest-indexed match wins.
REQ-018 With no match, or with cam_enable=0, or with cam_busy=1 at the sampling edge, the block SHALL drive cam_hit_out=0 and cam_addr_out=0 after the edge.
REQ-019 A write SHALL take effect at the edge where cam_wr_en=1; a search sampled at that same edge SHALL see the pre-write contents.
REQ-020 cam_wr_addr >= DEPTH SHALL be ignored, with no entry changed.
REQ-021 The state machine SHALL have states IDLE and FLUSH, with the following transitions:
- IDLE -> FLUSH on cam_flush=1; the index counter loads 0.
- In FLUSH, one entry is invalidated per cycle, at the counter index, and the counter then increments.
- FLUSH -> IDLE after entry DEPTH-1 is cleared, so FLUSH lasts exactly DEPTH cycles.
REQ-022 cam_busy SHALL be 1 exactly while in FLUSH.
REQ-023 In FLUSH, cam_wr_en, cam_flush and cam_enable SHALL be ignored.
REQ-024 In IDLE, when cam_flush and cam_wr_en are asserted together, the flush SHALL win and the write SHALL be dropped.
REQ-025 The flush counter SHALL be ADDR_W+1 bits wide and SHALL NOT wrap within a flush.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, clear all valid bits and set the state to IDLE, the counter to 0, and cam_hit_out, cam_addr_out and cam_busy to 0.
REQ-027 Reset mid-FLUSH SHALL abort the flush; all entries SHALL be invalid after reset regardless.
REQ-028 Stored data words SHALL NOT be reset; only the valid bits govern matching.

Configuration
REQ-029 With macro CAM_MULTI_HIT_EN defined, the block SHALL add the following outputs, registered with the same timing and zeroing rules as cam_hit_out:
- cam_multi_hit_out, 1 bit: 1 when two or more entries match.
- cam_hit_count_out, ADDR_W+1 bits: number of matching entries.
REQ-030 Without CAM_MULTI_HIT_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults DATA_W=16, DEPTH=16)
REQ-031 Write 0xBEEF to entry 5, then search 0xBEEF -> next cycle cam_hit_out=1 and cam_addr_out=5; searching 0xBEEE instead -> cam_hit_out=0 and cam_addr_out=0.
REQ-032 Write 0x1234 to entries 9 and 3, then search 0x1234 -> cam_addr_out=3; with CAM_MULTI_HIT_EN, cam_multi_hit_out=1 and cam_hit_count_out=2.
REQ-033 Write 0xAAAA to entry 2 in the same cycle as a search for 0xAAAA -> that search misses; a repeat search one cycle later hits with cam_addr_out=2.
REQ-034 Fill all 16 entries, pulse cam_flush -> cam_busy=1 for exactly 16 cycles, with searches and writes during that time ignored; afterwards every search misses.
REQ-035 Write entry 7 with 0x00FF, then invalidate it with cam_wr_valid=0 -> a search for 0x00FF misses.
REQ-036 Assert rst_n=0 during cycle 6 of a flush -> cam_busy=0 immediately with no clock edge, and all entries miss afterwards.
